// File: rtl/csr_multi_buffer_pkg.sv
// Shared types and defaults for the CSR multi-entry issue buffer.
package csr_multi_buffer_pkg;

  localparam int unsigned TRANS_ID_BITS      = 3;
  localparam int unsigned NR_CSR_BUF_ENTRIES = 4;

  // Functional-unit operand bundle as delivered by the issue stage.
  typedef struct packed {
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  // One pending CSR op: the address it will touch and its scoreboard id.
  typedef struct packed {
    logic [11:0]              csr_address;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } csr_buf_entry_t;

endpackage

// File: rtl/csr_buf_fifo.sv
// Generic in-order storage for pending CSR entries: pointers, count, per-slot valid bits.
// Full/empty come from the count; pointers wrap naturally (DEPTH is a power of two).
module csr_buf_fifo
  import csr_multi_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = NR_CSR_BUF_ENTRIES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  csr_buf_entry_t         wdata_i,
  output csr_buf_entry_t         head_o,
  output logic                   head_valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  csr_buf_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DEPTH-1:0]     valid_q, valid_d;

  // Next-state for pointers, count and valid bits; clear wins over push/pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      // Pop clears first so a same-slot push (full + pop) leaves the slot valid.
      if (pop_i) begin
        valid_d[rptr_q] = 1'b0;
        rptr_d          = rptr_q + PTR_W'(1);
      end else begin
        rptr_d = rptr_q;
      end
      if (push_i) begin
        valid_d[wptr_q] = 1'b1;
        wptr_d          = wptr_q + PTR_W'(1);
      end else begin
        wptr_d = wptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage; contents are don't-care until the slot is marked valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign head_o       = mem_q[rptr_q];
  assign head_valid_o = valid_q[rptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/csr_multi_buffer_chk.sv
// Protocol checks for the CSR buffer; reports issue/commit misuse without affecting state.
module csr_multi_buffer_chk (
  input logic clk_i,
  input logic rst_i,
  input logic flush_i,
  input logic csr_valid_i,
  input logic csr_ready_o,
  input logic csr_commit_i,
  input logic csr_addr_valid_o
);

  // Issue stage must not offer an op the buffer cannot take.
  a_issue_when_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    !(csr_valid_i && !csr_ready_o))
    else $warning("csr_multi_buffer: issue while not ready, op dropped");

  // Commit stage must only retire an existing entry.
  a_commit_not_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(csr_commit_i && !csr_addr_valid_o))
    else $warning("csr_multi_buffer: commit on empty buffer ignored");

  // Commit and flush are mutually exclusive from the commit stage.
  a_no_flush_commit: assert property (@(posedge clk_i) disable iff (rst_i)
    !(flush_i && csr_commit_i))
    else $warning("csr_multi_buffer: commit in flush cycle");

endmodule

// File: rtl/csr_multi_buffer.sv
// In-order buffer of CSR addresses for issued-but-uncommitted CSR ops.
// Adds ready/bypass, flush priority and the result path around csr_buf_fifo.
module csr_multi_buffer
  import csr_multi_buffer_pkg::*;
#(
  parameter int unsigned DEPTH        = NR_CSR_BUF_ENTRIES,
  parameter int unsigned BYPASS_READY = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  fu_data_t                 fu_data_i,
  input  logic                     csr_valid_i,
  output logic                     csr_ready_o,
  output logic [63:0]              csr_result_o,
  input  logic                     csr_commit_i,
  output logic [11:0]              csr_addr_o,
  output logic                     csr_addr_valid_o,
  output logic [TRANS_ID_BITS-1:0] csr_trans_id_o,
  output logic [$clog2(DEPTH):0]   usage_o
);

  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic BYPASS_EN = (BYPASS_READY != 0);

  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic             head_valid_s;
  logic [CNT_W-1:0] count_s;
  csr_buf_entry_t   wdata_s;
  csr_buf_entry_t   head_s;
  logic             unused_operand_b;

  // Full buffer can still accept when the commit stage frees the head this cycle.
  assign ready_s = (count_s < FULL_CNT) |
                   (BYPASS_EN & csr_commit_i & (count_s == FULL_CNT));

  // Flush discards any same-cycle push or pop.
  assign push_s = csr_valid_i & ready_s & ~flush_i;
  assign pop_s  = csr_commit_i & head_valid_s & ~flush_i;

  assign wdata_s.csr_address = fu_data_i.operand_b[11:0];
  assign wdata_s.trans_id    = fu_data_i.trans_id;
  assign unused_operand_b    = ^fu_data_i.operand_b[63:12];

  csr_buf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (flush_i),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .wdata_i      (wdata_s),
    .head_o       (head_s),
    .head_valid_o (head_valid_s),
    .count_o      (count_s)
  );

  csr_multi_buffer_chk u_chk (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .csr_valid_i      (csr_valid_i),
    .csr_ready_o      (ready_s),
    .csr_commit_i     (csr_commit_i),
    .csr_addr_valid_o (head_valid_s)
  );

  // Head fields are zeroed when empty so stale storage never leaks downstream.
  assign csr_addr_o       = head_valid_s ? head_s.csr_address : 12'h000;
  assign csr_trans_id_o   = head_valid_s ? head_s.trans_id : '0;
  assign csr_addr_valid_o = head_valid_s;
  assign csr_ready_o      = ready_s;
  assign csr_result_o     = fu_data_i.operand_a;
  assign usage_o          = count_s;

endmodule

// File: tb/tb_csr_multi_buffer.sv
// Self-checking bench: two DEPTH=4 instances (bypass on/off) share stimulus and
// are compared every cycle against a queue-based model, plus directed literal checks.
module tb_csr_multi_buffer;
  import csr_multi_buffer_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [11:0] a;
    logic [2:0]  t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid;
  logic        commit;
  fu_data_t    fu;

  logic [1:0]  rdy;
  logic [1:0]  av;
  logic [63:0] res  [2];
  logic [11:0] addr [2];
  logic [2:0]  tid  [2];
  logic [2:0]  usage[2];

  int checks = 0;
  int errors = 0;

  ent_t mq[2][$];

  always #5 clk = ~clk;

  csr_multi_buffer #(.DEPTH(DEPTH), .BYPASS_READY(0)) u_dut_b0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .fu_data_i(fu),
    .csr_valid_i(valid), .csr_ready_o(rdy[0]), .csr_result_o(res[0]),
    .csr_commit_i(commit), .csr_addr_o(addr[0]), .csr_addr_valid_o(av[0]),
    .csr_trans_id_o(tid[0]), .usage_o(usage[0])
  );

  csr_multi_buffer #(.DEPTH(DEPTH), .BYPASS_READY(1)) u_dut_b1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .fu_data_i(fu),
    .csr_valid_i(valid), .csr_ready_o(rdy[1]), .csr_result_o(res[1]),
    .csr_commit_i(commit), .csr_addr_o(addr[1]), .csr_addr_valid_o(av[1]),
    .csr_trans_id_o(tid[1]), .usage_o(usage[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready(input int b);
    return (mq[b].size() < DEPTH) || (b == 1 && commit && mq[b].size() == DEPTH);
  endfunction

  // Reference model: plain FIFO queue per instance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq[0].delete();
      mq[1].delete();
    end else if (flush) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      for (int b = 0; b < 2; b++) begin
        logic do_push;
        logic do_pop;
        do_push = valid && exp_ready(b);
        do_pop  = commit && (mq[b].size() > 0);
        if (do_pop) void'(mq[b].pop_front());
        if (do_push) mq[b].push_back(ent_t'{fu.operand_b[11:0], fu.trans_id});
      end
    end
  end

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      logic [11:0] ea;
      logic [2:0]  et;
      ea = 12'h000;
      et = 3'd0;
      if (mq[b].size() > 0) begin
        ea = mq[b][0].a;
        et = mq[b][0].t;
      end
      chk($sformatf("ready[%0d]", b), {63'd0, rdy[b]}, {63'd0, exp_ready(b)});
      chk($sformatf("addr_valid[%0d]", b), {63'd0, av[b]}, {63'd0, mq[b].size() > 0});
      chk($sformatf("addr[%0d]", b), {52'd0, addr[b]}, {52'd0, ea});
      chk($sformatf("trans_id[%0d]", b), {61'd0, tid[b]}, {61'd0, et});
      chk($sformatf("usage[%0d]", b), {61'd0, usage[b]}, 64'(mq[b].size()));
      chk($sformatf("result[%0d]", b), res[b], fu.operand_a);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid  = 1'b0;
    commit = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic set_push(input logic [11:0] a, input logic [2:0] t);
    valid            = 1'b1;
    fu.operand_a     = {$urandom, $urandom};
    fu.operand_b     = {$urandom, 20'h00000, a};
    fu.trans_id      = t;
  endtask

  initial begin
    logic [11:0] seq [3];
    seq[0] = 12'h300; seq[1] = 12'h305; seq[2] = 12'h341;
    rst = 1'b1;
    idle();
    fu = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, rdy[1]}, 64'd1);
    chk("rst_addr_valid", {63'd0, av[1]}, 64'd0);
    chk("rst_addr", {52'd0, addr[1]}, 64'd0);
    chk("rst_usage", {61'd0, usage[1]}, 64'd0);
    rst = 1'b0;
    step();

    // Three pushes, then in-order commits.
    for (int i = 0; i < 3; i++) begin
      set_push(seq[i], 3'(i + 1));
      step();
    end
    idle();
    chk("t1_usage", {61'd0, usage[1]}, 64'd3);
    chk("t1_head", {52'd0, addr[1]}, 64'h300);
    commit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_order", {52'd0, addr[1]}, {52'd0, seq[i]});
      chk("t1_pop_tid", {61'd0, tid[1]}, 64'(i + 1));
      step();
    end
    idle();
    chk("t1_empty", {63'd0, av[1]}, 64'd0);

    // Fill, then push+commit on full: bypass vs. no bypass.
    for (int i = 0; i < 4; i++) begin
      set_push(12'h100 + 12'(i), 3'(i));
      step();
    end
    idle();
    chk("t2_full_ready_b1", {63'd0, rdy[1]}, 64'd0);
    chk("t2_full_ready_b0", {63'd0, rdy[0]}, 64'd0);
    set_push(12'h1AA, 3'd7);
    commit = 1'b1;
    #1;
    chk("t2_bypass_ready_b1", {63'd0, rdy[1]}, 64'd1);
    chk("t2_bypass_ready_b0", {63'd0, rdy[0]}, 64'd0);
    step();
    idle();
    chk("t2_usage_b1", {61'd0, usage[1]}, 64'd4);
    chk("t2_head_b1", {52'd0, addr[1]}, 64'h101);
    chk("t2_usage_b0", {61'd0, usage[0]}, 64'd3);
    flush = 1'b1;
    step();
    idle();
    chk("t2_flushed", {61'd0, usage[1]}, 64'd0);

    // Interleaved push/commit pairs across pointer wrap.
    set_push(12'h200, 3'd0);
    step();
    for (int i = 1; i <= 10; i++) begin
      set_push(12'h200 + 12'(i), 3'(i));
      commit = 1'b1;
      chk("t3_wrap_head", {52'd0, addr[1]}, 64'h200 + 64'(i - 1));
      step();
      chk("t3_usage", {61'd0, usage[1]}, 64'd1);
    end
    idle();
    commit = 1'b1;
    chk("t3_last", {52'd0, addr[1]}, 64'h20A);
    step();
    idle();

    // Flush with 3 entries and a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      set_push(12'h3A0 + 12'(i), 3'(i));
      step();
    end
    set_push(12'hBAD, 3'd5);
    flush = 1'b1;
    step();
    idle();
    chk("t4_usage", {61'd0, usage[1]}, 64'd0);
    chk("t4_addr_valid", {63'd0, av[1]}, 64'd0);
    chk("t4_ready", {63'd0, rdy[1]}, 64'd1);
    step();
    chk("t4_no_ghost", {52'd0, addr[1]}, 64'd0);

    // Push on empty with a concurrent (illegal) commit.
    set_push(12'h7C0, 3'd2);
    fu.operand_a = 64'h1234_5678_9ABC_DEF0;
    commit = 1'b1;
    #1;
    chk("t5_result", res[1], 64'h1234_5678_9ABC_DEF0);
    step();
    idle();
    chk("t5_usage", {61'd0, usage[1]}, 64'd1);
    chk("t5_head", {52'd0, addr[1]}, 64'h7C0);
    commit = 1'b1;
    step();
    idle();

    // Asynchronous reset mid-burst.
    set_push(12'h011, 3'd1);
    step();
    set_push(12'h022, 3'd2);
    step();
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_usage", {61'd0, usage[1]}, 64'd0);
    chk("t6_async_av", {63'd0, av[1]}, 64'd0);
    chk("t6_async_addr", {52'd0, addr[1]}, 64'd0);
    chk("t6_async_ready", {63'd0, rdy[1]}, 64'd1);
    step();
    rst = 1'b0;
    set_push(12'h3FF, 3'd6);
    step();
    idle();
    chk("t6_after_rst", {52'd0, addr[1]}, 64'h3FF);
    chk("t6_after_rst_usage", {61'd0, usage[1]}, 64'd1);

    // Randomized legal traffic.
    for (int n = 0; n < 500; n++) begin
      flush  = ($urandom_range(0, 24) == 0);
      commit = !flush && (mq[0].size() > 0) && ($urandom_range(0, 1) == 1);
      if (($urandom_range(0, 2) != 0) && exp_ready(0)) begin
        set_push(12'($urandom), 3'($urandom));
      end else begin
        valid        = 1'b0;
        fu.operand_a = {$urandom, $urandom};
      end
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
